// File: rtl/adc_capture_buffer.sv
// Pre/post-trigger capture of multi-channel ADC AXI4-Stream beats into a circular
// beat buffer, replayed afterwards as a gap-free serial sample stream.
module adc_capture_buffer #(
   parameter int unsigned NCHAN       = 1,
   parameter int unsigned LANES       = 8,
   parameter int unsigned SAMPLE_BITS = 12,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned PRETRIG     = 16,
   localparam int unsigned CHAN_W     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [NCHAN*LANES*16-1:0] adc_tdata,
   input  logic                      adc_tvalid,
   input  logic                      trigger_in,
   output logic                      trigger_ack,
   output logic [SAMPLE_BITS-1:0]    adc_out,
   output logic [CHAN_W-1:0]         adc_chan,
   output logic                      adc_valid,
   output logic                      adc_last,
   output logic                      busy
);

   localparam int unsigned AW         = $clog2(DEPTH);
   localparam int unsigned LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned WORD_W     = NCHAN * LANES * SAMPLE_BITS;
   localparam int unsigned CNT_W      = AW + 1;
   localparam int unsigned POST_BEATS = DEPTH - PRETRIG - 1;

   typedef enum logic [1:0] {FILL, WAIT, POST, READOUT} state_t;

   state_t                   state_q, state_d;
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     pend_q, pend_d;
   logic [AW-1:0]            rd_beat_q, rd_beat_d;
   logic [CHAN_W-1:0]        rd_chan_q, rd_chan_d;
   logic [LANE_W-1:0]        rd_lane_q, rd_lane_d;
   logic                     done_q, done_d;
   logic                     ack_q, ack_d;
   logic [SAMPLE_BITS-1:0]   out_q, out_d;
   logic [CHAN_W-1:0]        chan_q, chan_d;
   logic                     valid_q, valid_d;
   logic                     last_q, last_d;
   logic                     busy_q, busy_d;

   logic [WORD_W-1:0]        mem_q [DEPTH];
   logic [WORD_W-1:0]        wr_word_c;
   logic [WORD_W-1:0]        rd_word_c;
   logic [AW-1:0]            rd_addr_c;
   logic [SAMPLE_BITS-1:0]   rd_sample_c;
   int unsigned              rd_sel_c;
   logic                     we_c;

   // Keep only the MSB-justified sample bits of every lane
   always_comb begin
      wr_word_c = '0;
      for (int c = 0; c < NCHAN; c++) begin
         for (int l = 0; l < LANES; l++) begin
            wr_word_c[(c*LANES+l)*SAMPLE_BITS +: SAMPLE_BITS] =
               adc_tdata[c*LANES*16 + l*16 + 15 -: SAMPLE_BITS];
         end
      end
   end

   // Write pointer is frozen during readout, so it marks the oldest stored beat
   always_comb begin
      rd_addr_c   = wr_ptr_q + rd_beat_q;
      rd_word_c   = mem_q[rd_addr_c];
      rd_sel_c    = 32'(rd_chan_q) * LANES + 32'(rd_lane_q);
      rd_sample_c = SAMPLE_BITS'(rd_word_c >> (rd_sel_c * SAMPLE_BITS));
   end

   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      cnt_d     = cnt_q;
      pend_d    = 1'b0;
      rd_beat_d = '0;
      rd_chan_d = '0;
      rd_lane_d = '0;
      done_d    = 1'b0;
      ack_d     = 1'b0;
      out_d     = '0;
      chan_d    = '0;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      we_c      = 1'b0;

      case (state_q)
         FILL: begin
            if (adc_tvalid) begin
               we_c = 1'b1;
               if (cnt_q == CNT_W'(PRETRIG - 1)) begin
                  cnt_d   = CNT_W'(PRETRIG);
                  state_d = WAIT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         WAIT: begin
            // A trigger seen without a valid beat waits for the next valid beat
            pend_d = pend_q | trigger_in;
            if (adc_tvalid) begin
               we_c = 1'b1;
               if (trigger_in || pend_q) begin
                  pend_d  = 1'b0;
                  ack_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = (POST_BEATS == 0) ? READOUT : POST;
               end
            end
         end
         POST: begin
            if (adc_tvalid) begin
               we_c = 1'b1;
               if (cnt_q == CNT_W'(POST_BEATS - 1)) begin
                  cnt_d   = '0;
                  state_d = READOUT;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         READOUT: begin
            rd_beat_d = rd_beat_q;
            rd_chan_d = rd_chan_q;
            rd_lane_d = rd_lane_q;
            if (done_q) begin
               state_d = FILL;
               cnt_d   = '0;
            end else begin
               valid_d = 1'b1;
               out_d   = rd_sample_c;
               chan_d  = rd_chan_q;
               if (rd_lane_q == LANE_W'(LANES - 1)) begin
                  rd_lane_d = '0;
                  if (rd_chan_q == CHAN_W'(NCHAN - 1)) begin
                     rd_chan_d = '0;
                     if (rd_beat_q == AW'(DEPTH - 1)) begin
                        last_d = 1'b1;
                        done_d = 1'b1;
                     end else begin
                        rd_beat_d = rd_beat_q + AW'(1);
                     end
                  end else begin
                     rd_chan_d = rd_chan_q + CHAN_W'(1);
                  end
               end else begin
                  rd_lane_d = rd_lane_q + LANE_W'(1);
               end
            end
         end
         default: state_d = FILL;
      endcase

      if (we_c) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      busy_d = (state_d == POST) || (state_d == READOUT);
   end

   always_ff @(posedge aclk) begin
      if (we_c) begin
         mem_q[wr_ptr_q] <= wr_word_c;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= FILL;
         wr_ptr_q  <= '0;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         rd_beat_q <= '0;
         rd_chan_q <= '0;
         rd_lane_q <= '0;
         done_q    <= 1'b0;
         ack_q     <= 1'b0;
         out_q     <= '0;
         chan_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         rd_beat_q <= rd_beat_d;
         rd_chan_q <= rd_chan_d;
         rd_lane_q <= rd_lane_d;
         done_q    <= done_d;
         ack_q     <= ack_d;
         out_q     <= out_d;
         chan_q    <= chan_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
      end
   end

   assign trigger_ack = ack_q;
   assign adc_out     = out_q;
   assign adc_chan    = chan_q;
   assign adc_valid   = valid_q;
   assign adc_last    = last_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer: a 2-channel/16-deep instance and a
// default-parameter instance share stimulus; sel picks which one is observed.
module tb_adc_capture_buffer;

   localparam int unsigned LANES = 8;
   localparam int unsigned SB    = 12;
   localparam int unsigned W2    = 2 * LANES * 16;
   localparam int unsigned W1    = LANES * 16;

   logic          aclk   = 1'b0;
   logic          areset = 1'b0;
   logic [W2-1:0] tdata2;
   logic [W1-1:0] tdata1;
   logic          tvalid = 1'b0;
   logic          trig   = 1'b0;
   logic          sel    = 1'b0;

   logic          ack2, valid2, last2, busy2;
   logic [SB-1:0] out2;
   logic [0:0]    chan2;
   logic          ack1, valid1, last1, busy1;
   logic [SB-1:0] out1;
   logic [0:0]    chan1;

   logic          mon_ack, mon_valid, mon_last, mon_busy, mon_chan;
   logic [SB-1:0] mon_out;

   int n_cmp = 0;
   int n_bad = 0;
   int beat_n = 0;

   adc_capture_buffer #(
      .NCHAN(2), .LANES(LANES), .SAMPLE_BITS(SB), .DEPTH(16), .PRETRIG(4)
   ) dut2 (
      .aclk(aclk), .areset(areset), .adc_tdata(tdata2), .adc_tvalid(tvalid),
      .trigger_in(trig), .trigger_ack(ack2), .adc_out(out2), .adc_chan(chan2),
      .adc_valid(valid2), .adc_last(last2), .busy(busy2)
   );

   adc_capture_buffer dut1 (
      .aclk(aclk), .areset(areset), .adc_tdata(tdata1), .adc_tvalid(tvalid),
      .trigger_in(trig), .trigger_ack(ack1), .adc_out(out1), .adc_chan(chan1),
      .adc_valid(valid1), .adc_last(last1), .busy(busy1)
   );

   always #5 aclk = ~aclk;

   always_comb begin
      mon_ack   = sel ? ack1   : ack2;
      mon_valid = sel ? valid1 : valid2;
      mon_last  = sel ? last1  : last2;
      mon_busy  = sel ? busy1  : busy2;
      mon_chan  = sel ? chan1[0] : chan2[0];
      mon_out   = sel ? out1   : out2;
   end

   function automatic logic [W2-1:0] mk2(input logic [7:0] n);
      logic [W2-1:0] d;
      d = '0;
      for (int c = 0; c < 2; c++)
         for (int l = 0; l < LANES; l++)
            d[c*LANES*16 + l*16 +: 16] = {n, 1'(c), 3'(l), 4'b0};
      return d;
   endfunction

   function automatic logic [W1-1:0] mk1(input logic [7:0] n);
      logic [W1-1:0] d;
      d = '0;
      for (int l = 0; l < LANES; l++)
         d[l*16 +: 16] = {n, 1'b0, 3'(l), 4'b0};
      return d;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   // One clock with the given inputs (0xEE filler data on idle cycles), then check the ack
   task automatic drive(input logic v, input logic t, input logic exp_ack);
      tvalid = v;
      trig   = t;
      tdata2 = mk2(v ? beat_n[7:0] : 8'hEE);
      tdata1 = mk1(v ? beat_n[7:0] : 8'hEE);
      @(negedge aclk);
      if (v) beat_n++;
      chk("trigger_ack", 32'(mon_ack), 32'(exp_ack));
   endtask

   // Entered right after the last post-trigger beat was clocked in; filler beats
   // offered meanwhile must be discarded
   task automatic readout(input int first, input int nch, input int nsamp);
      int b, c, l, total;
      logic [31:0] want;
      total  = (sel ? 64 : 16) * nch * int'(LANES);
      tvalid = 1'b1;
      tdata2 = mk2(8'hEE);
      tdata1 = mk1(8'hEE);
      chk("valid_gap", 32'(mon_valid), 32'd0);
      chk("busy_readout", 32'(mon_busy), 32'd1);
      for (int s = 0; s < nsamp; s++) begin
         @(negedge aclk);
         b = first + s / (nch * int'(LANES));
         c = (s / int'(LANES)) % nch;
         l = s % int'(LANES);
         want = {17'b0, 1'b1, 8'(b), 1'(c), 3'(l), 1'(c), 1'(s == total - 1)};
         chk("sample", {17'b0, mon_valid, mon_out, mon_chan, mon_last}, want);
      end
      if (nsamp == total) begin
         @(negedge aclk);
         chk("valid_after_last", 32'(mon_valid), 32'd0);
         chk("busy_after_last", 32'(mon_busy), 32'd0);
         chk("out_after_last", 32'(mon_out), 32'd0);
         tvalid = 1'b0;
      end
   endtask

   initial begin
      tdata2 = '0;
      tdata1 = '0;

      // Asynchronous reset before any clock edge
      #1 areset = 1'b1;
      #1;
      chk("rst_ack", 32'(ack2), 32'd0);
      chk("rst_valid", 32'(valid2), 32'd0);
      chk("rst_out", 32'(out2), 32'd0);
      chk("rst_chan", 32'(chan2), 32'd0);
      chk("rst_last", 32'(last2), 32'd0);
      chk("rst_busy", 32'(busy2), 32'd0);
      chk("rst_valid1", 32'(valid1), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      @(negedge aclk);
      areset = 1'b0;

      // Trigger at beat 10 -> readout beats 6..21
      beat_n = 0;
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
      chk("busy_wait", 32'(mon_busy), 32'd0);
      drive(1'b1, 1'b1, 1'b1);
      chk("busy_post", 32'(mon_busy), 32'd1);
      for (int i = 0; i < 11; i++) drive(1'b1, 1'b0, 1'b0);
      readout(6, 2, 256);

      // Trigger during FILL ignored; held-off trigger; sparse valid in POST
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
      chk("busy_fill_trig", 32'(mon_busy), 32'd0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 11; i++) begin
         drive(1'b1, 1'b0, 1'b0);
         if (i < 10) begin
            drive(1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0);
         end
      end
      readout(22, 2, 256);

      // Trigger held high: one ack per capture
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 11; i++) drive(1'b1, 1'b1, 1'b0);
      readout(38, 2, 256);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 11; i++) drive(1'b1, 1'b1, 1'b0);

      // Reset while sample 100 is on the output
      readout(54, 2, 100);
      areset = 1'b1;
      #1;
      chk("abort_valid", 32'(mon_valid), 32'd0);
      chk("abort_busy", 32'(mon_busy), 32'd0);
      chk("abort_out", 32'(mon_out), 32'd0);
      @(negedge aclk);
      areset = 1'b0;
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0);
      chk("abort_no_samples", 32'(mon_valid), 32'd0);
      beat_n = 70;
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0);
      chk("abort_busy_fill", 32'(mon_busy), 32'd0);
      drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 11; i++) drive(1'b1, 1'b1, 1'b0);
      readout(70, 2, 256);

      // Default single-channel instance, trigger on first WAIT beat
      trig   = 1'b0;
      sel    = 1'b1;
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      beat_n = 0;
      for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 47; i++) drive(1'b1, 1'b0, 1'b0);
      readout(0, 1, 512);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_capture_buffer.md
ADC_CAPTURE_BUFFER -- requirements
Module: adc_capture_buffer

Interface
REQ-001 Parameter NCHAN, default 1: number of ADC AXI4-Stream channels captured (1..4).
REQ-002 Parameter LANES, default 8: 16-bit sample lanes per channel beat (128-bit beat at default).
REQ-003 Parameter SAMPLE_BITS, default 12: sample width taken MSB-justified from each 16-bit lane.
REQ-004 Parameter DEPTH, default 64: beats stored per capture; power of 2, at least 4.
REQ-005 Parameter PRETRIG, default 16: beats kept before the trigger beat; 1 <= PRETRIG < DEPTH.
REQ-006 aclk  input  1  sole clock, all logic on rising edge.
REQ-007 areset  input  1  asynchronous, active-high reset.
REQ-008 adc_tdata  input  NCHAN*LANES*16  channel c occupies bits [c*LANES*16 +: LANES*16].
REQ-009 adc_tvalid  input  1  beat valid, common to all channels.
REQ-010 trigger_in  input  1  capture request, level-sampled.
REQ-011 trigger_ack  output  1  one-cycle pulse acknowledging an accepted trigger.
REQ-012 adc_out  output  SAMPLE_BITS  serialized sample, lane l = bits [16*l+15 -: SAMPLE_BITS].
REQ-013 adc_chan  output  max(1,clog2(NCHAN))  channel index of adc_out.
REQ-014 adc_valid  output  1  adc_out/adc_chan valid this cycle.
REQ-015 adc_last  output  1  high with the final sample of a capture.
REQ-016 busy  output  1  high in POST and READOUT.

Function
REQ-017 States FILL, WAIT, POST, READOUT; circular beat buffer of DEPTH x NCHAN*LANES*SAMPLE_BITS.
REQ-018 Only beats with adc_tvalid=1 are written or counted; write pointer wraps modulo DEPTH.
REQ-019 FILL: write valid beats, count saturating at PRETRIG; enter WAIT on the cycle the PRETRIG-th beat is written.
REQ-020 WAIT: keep writing; trigger_in=1 with adc_tvalid=1 accepts the trigger, that cycle's beat is the trigger beat, enter POST.
REQ-021 trigger_in=1 with adc_tvalid=0 in WAIT is held off until the next valid beat; trigger_in in FILL, POST, READOUT is ignored and not acked.
REQ-022 trigger_ack pulses high exactly one cycle, in the cycle after acceptance.
REQ-023 POST: write DEPTH-PRETRIG-1 further valid beats; after the last write, stop writing and enter READOUT.
REQ-024 READOUT: samples emitted oldest beat first (PRETRIG beats before the trigger beat), order beat outer, channel middle, lane inner.
REQ-025 One sample per cycle, no gaps, DEPTH*NCHAN*LANES samples total; adc_valid first high exactly 2 cycles after the last POST write.
REQ-026 adc_last high with sample DEPTH*NCHAN*LANES only; next cycle adc_valid=0, state FILL, count cleared.
REQ-027 Input beats during READOUT are discarded; no back-pressure exists.
REQ-028 adc_out and adc_chan are 0 whenever adc_valid=0.

Reset
REQ-029 areset asserted forces, without a clock edge, state FILL, count 0, write pointer 0, and trigger_ack, adc_out, adc_chan, adc_valid, adc_last, busy all 0.
REQ-030 Reset mid-operation abandons the capture; buffer contents need not be cleared; a new capture requires PRETRIG fresh valid beats.

Verification
REQ-031 NCHAN=2, DEPTH=16, PRETRIG=4; beat n lane l ch c = {n[7:0],c[0],l[2:0]}<<4; trigger at beat 10 -> trigger_ack at cycle after beat 10, readout beats 6..21, first sample beat 6 ch0 lane0, adc_last on sample 256.
REQ-032 Same config, trigger_in=1 during first 3 valid beats then 0 -> no trigger_ack, busy stays 0, state reaches WAIT after beat 4.
REQ-033 adc_tvalid toggling 1,0,0,1 during POST -> readout beats contiguous, no duplicates, 16 beats, first adc_valid 2 cycles after 11th post-trigger valid beat.
REQ-034 trigger_in held 1 permanently -> exactly one trigger_ack per capture; second capture begins after 4 valid beats following adc_last.
REQ-035 areset pulsed during READOUT sample 100 -> adc_valid, busy 0 immediately; no further samples; next trigger accepted only after 4 new valid beats.
REQ-036 NCHAN=1 defaults with trigger on first WAIT beat -> 512 samples, adc_chan constant 0, adc_last only on sample 512.
